// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into big-endian 32-bit words and writes
// them to instruction memory at byte addresses 0, 4, 8, ...  Loading ends
// after the all-ones halt sentinel is written, or with an error when the
// memory fills before the sentinel arrives.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 8192,
  parameter int unsigned CNT_WIDTH   = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] words_written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [31:0] LAST_ADDR = 32'(DEPTH_WORDS * 4 - 4);

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_idx;
  logic [31:0]          r_word;
  logic [31:0]          r_addr;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic w_accept;
  logic w_start_ok;
  logic w_sentinel;
  logic w_last;

  assign w_accept   = (r_state == S_LOAD) && byte_valid;
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                (r_state == S_ERR));
  assign w_sentinel = (r_word == '1);
  assign w_last     = (r_addr == LAST_ADDR);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next = S_LOAD;
      S_LOAD:  if (w_accept && (r_idx == 2'd3)) w_next = S_WRITE;
      S_WRITE: begin
        if (w_sentinel)  w_next = S_DONE;
        else if (w_last) w_next = S_ERR;
        else             w_next = S_LOAD;
      end
      S_DONE:  if (w_start_ok) w_next = S_LOAD;
      S_ERR:   if (w_start_ok) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  // Byte packing, write address and word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_word <= '0;
      r_addr <= '0;
      r_cnt  <= '0;
    end else if (w_start_ok) begin
      r_idx  <= '0;
      r_word <= '0;
      r_addr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_accept) begin
        // shifting left four times leaves the first byte in the MSB
        r_word <= {r_word[23:0], byte_in};
        r_idx  <= r_idx + 2'd1;
      end
      if (r_state == S_WRITE) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
        if (!w_sentinel && !w_last) begin
          r_addr <= r_addr + 32'd4;
        end
      end
    end
  end

  // Output decode from state and registered datapath
  always_comb begin
    byte_ready    = (r_state == S_LOAD);
    mem_we        = (r_state == S_WRITE);
    busy          = (r_state == S_LOAD) || (r_state == S_WRITE);
    done          = (r_state == S_DONE);
    overflow      = (r_state == S_ERR);
    mem_addr      = r_addr;
    mem_wdata     = r_word;
    words_written = r_cnt;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader, built with a 4-word memory so the
// overflow path is reachable.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [2:0]  words_written;

  int total = 0;
  int bad   = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];
  int          cyc = 0;
  int          hs_bad = 0;

  imem_loader #(.DEPTH_WORDS(4), .CNT_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .overflow(overflow), .words_written(words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // write monitor and handshake watch, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      log_cyc.push_back(cyc);
    end
    if (busy && (byte_ready == mem_we)) hs_bad <= hs_bad + 1;
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Present one byte and hold it until accepted; returns at a negedge
  // with byte_valid still high.
  task automatic send_byte(input logic [7:0] b);
    logic s;
    int   t;
    t = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    forever begin
      s = byte_ready;
      @(negedge clk);
      if (s) break;
      t++;
      if (t > 50) begin
        total++; bad++;
        $display("FAIL send_byte_timeout byte=%02h ready stayed 0, required 1", b);
        break;
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) @(negedge clk);
    total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", byte_ready); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", mem_we); end
    total++; if ({busy, done, overflow} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {busy, done, overflow}); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", mem_wdata); end
    total++; if (words_written !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", words_written); end
    rst = 1'b0;
    idle(2);
    total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL idle_ready got=%b exp=0", byte_ready); end
  endtask

  task automatic test_basic();
    clear_log();
    pulse_start();
    total++; if (byte_ready !== 1'b1) begin bad++; $display("FAIL start_ready got=%b exp=1", byte_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%b exp=1", busy); end
    send_word(32'h00000020);
    send_word(32'hFFFFFFFF);
    idle(3);
    total++; if (log_addr.size() !== 2) begin bad++; $display("FAIL basic_nwrites got=%0d exp=2", log_addr.size()); end
    if (log_addr.size() == 2) begin
      total++; if (log_addr[0] !== 32'h0 || log_data[0] !== 32'h00000020) begin bad++; $display("FAIL basic_w0 got=%h/%h exp=0/00000020", log_addr[0], log_data[0]); end
      total++; if (log_addr[1] !== 32'h4 || log_data[1] !== 32'hFFFFFFFF) begin bad++; $display("FAIL basic_w1 got=%h/%h exp=4/ffffffff", log_addr[1], log_data[1]); end
    end
    total++; if ({busy, done, overflow} !== 3'b010) begin bad++; $display("FAIL basic_flags got=%b exp=010", {busy, done, overflow}); end
    total++; if (words_written !== 3'd2) begin bad++; $display("FAIL basic_count got=%0d exp=2", words_written); end
    total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL done_ready got=%b exp=0", byte_ready); end
  endtask

  task automatic test_stall();
    logic [31:0] w;
    w = 32'h8C010004;
    clear_log();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      idle(3);
      send_byte(w[31-8*i -: 8]);
    end
    idle(6);
    total++; if (log_addr.size() !== 1) begin bad++; $display("FAIL stall_nwrites got=%0d exp=1", log_addr.size()); end
    if (log_addr.size() >= 1) begin
      total++; if (log_addr[0] !== 32'h0 || log_data[0] !== 32'h8C010004) begin bad++; $display("FAIL stall_w0 got=%h/%h exp=0/8c010004", log_addr[0], log_data[0]); end
    end
    total++; if (words_written !== 3'd1) begin bad++; $display("FAIL stall_count got=%0d exp=1", words_written); end
    total++; if ({busy, byte_ready} !== 2'b11) begin bad++; $display("FAIL stall_load got=%b exp=11", {busy, byte_ready}); end
  endtask

  task automatic test_overflow();
    int seen;
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    clear_log();
    pulse_start();
    for (int i = 0; i < 4; i++) send_word(32'h01020304 + 32'(i));
    idle(2);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    total++; if ({busy, done, byte_ready} !== 3'b000) begin bad++; $display("FAIL ovf_state got=%b exp=000", {busy, done, byte_ready}); end
    // fifth word offered but must never be taken
    seen = 0;
    byte_in = 8'h55; byte_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (byte_ready || mem_we) seen++;
    end
    byte_valid = 1'b0;
    total++; if (seen !== 0) begin bad++; $display("FAIL ovf_fifth got=%0d active cycles exp=0", seen); end
    total++; if (log_addr.size() !== 4) begin bad++; $display("FAIL ovf_nwrites got=%0d exp=4", log_addr.size()); end
    if (log_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (log_addr[i] !== 32'(4*i) || log_data[i] !== 32'h01020304 + 32'(i)) begin
          bad++; $display("FAIL ovf_w%0d got=%h/%h exp=%h/%h", i, log_addr[i], log_data[i], 32'(4*i), 32'h01020304 + 32'(i));
        end
      end
    end
    total++; if (words_written !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", words_written); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    pulse_start();
    send_byte(8'hAA);
    send_byte(8'hBB);
    byte_valid = 1'b0;
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    total++; if ({busy, byte_ready, mem_we} !== 3'b000) begin bad++; $display("FAIL midrst_idle got=%b exp=000", {busy, byte_ready, mem_we}); end
    pulse_start();
    send_word(32'h12345678);
    send_word(32'hFFFFFFFF);
    idle(2);
    total++; if (log_addr.size() !== 2) begin bad++; $display("FAIL midrst_nwrites got=%0d exp=2", log_addr.size()); end
    if (log_addr.size() >= 1) begin
      total++; if (log_addr[0] !== 32'h0 || log_data[0] !== 32'h12345678) begin bad++; $display("FAIL midrst_w0 got=%h/%h exp=0/12345678", log_addr[0], log_data[0]); end
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL midrst_done got=%b exp=1", done); end
  endtask

  task automatic test_restart();
    clear_log();
    pulse_start();
    total++; if ({busy, done, words_written} !== {2'b10, 3'd0}) begin bad++; $display("FAIL restart_clear got=%b/%0d exp=10/0", {busy, done}, words_written); end
    send_byte(8'hDE);
    send_byte(8'hAD);
    byte_valid = 1'b0;
    pulse_start();
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_word(32'hFFFFFFFF);
    idle(2);
    total++; if (log_addr.size() !== 2) begin bad++; $display("FAIL restart_nwrites got=%0d exp=2", log_addr.size()); end
    if (log_addr.size() == 2) begin
      total++; if (log_addr[0] !== 32'h0 || log_data[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL restart_w0 got=%h/%h exp=0/deadbeef", log_addr[0], log_data[0]); end
      total++; if (log_addr[1] !== 32'h4 || log_data[1] !== 32'hFFFFFFFF) begin bad++; $display("FAIL restart_w1 got=%h/%h exp=4/ffffffff", log_addr[1], log_data[1]); end
    end
    total++; if (words_written !== 3'd2) begin bad++; $display("FAIL restart_count got=%0d exp=2", words_written); end
  endtask

  task automatic test_back_to_back();
    clear_log();
    pulse_start();
    hs_bad = 0;
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    send_word(32'hFFFFFFFF);
    idle(2);
    total++; if (hs_bad !== 0) begin bad++; $display("FAIL b2b_handshake got=%0d bad cycles exp=0", hs_bad); end
    total++; if (log_addr.size() !== 4) begin bad++; $display("FAIL b2b_nwrites got=%0d exp=4", log_addr.size()); end
    if (log_addr.size() == 4) begin
      for (int i = 1; i < 4; i++) begin
        total++; if (log_cyc[i] - log_cyc[i-1] !== 5) begin bad++; $display("FAIL b2b_gap%0d got=%0d exp=5", i, log_cyc[i] - log_cyc[i-1]); end
      end
      total++; if (log_addr[3] !== 32'hC || log_data[3] !== 32'hFFFFFFFF) begin bad++; $display("FAIL b2b_w3 got=%h/%h exp=c/ffffffff", log_addr[3], log_data[3]); end
    end
    total++; if ({done, overflow} !== 2'b10) begin bad++; $display("FAIL b2b_flags got=%b exp=10", {done, overflow}); end
    total++; if (words_written !== 3'd4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", words_written); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_restart();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
